// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one memory op at a time from EX to data memory, aligned/extended result to WB.
// Latency: accept -> resp_valid in 3 cycles with a first-cycle ack, 2 cycles for a misaligned op.
// Backpressure: req_ready only in IDLE (stall otherwise); DM request held until mem_ack or timeout.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready EX handshake with op, addr, store_data
//   mem_*               word-aligned DM request (req, we, addr, be, wdata), mem_ack/mem_rdata back
//   resp_valid          one-cycle completion pulse with load_data and err (0 ok, 1 misaligned, 2 timeout)
//   stall               high whenever the unit is not idle
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  output logic [31:0]       load_data,
  output logic [1:0]        err,
  output logic              stall
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_BUS   = 2'd2;

  // Counter value seen in the TIMEOUT-th ACCESS cycle (it starts at 0 in the first one).
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       sd_q;
  logic [31:0]       rdata_q;
  logic [1:0]        err_q, err_nxt;
  logic [7:0]        cnt_q;
  logic              misaligned;
  logic              is_store, is_word, is_half;
  logic [3:0]        be_dec;
  logic [31:0]       wdata_dec;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       load_ext;

  // Alignment of the incoming op; only meaningful while accepting in IDLE.
  always_comb begin
    misaligned = 1'b0;
    case (op)
      OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
      default:              misaligned = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            state_nxt = RESP;
            err_nxt   = ERR_ALIGN;
          end else begin
            state_nxt = ACCESS;
            err_nxt   = ERR_OK;
          end
        end
      end
      ACCESS: begin
        // An ack in the final allowed cycle still completes normally.
        if (mem_ack) begin
          state_nxt = RESP;
          err_nxt   = ERR_OK;
        end else if (cnt_q == TO_LAST) begin
          state_nxt = RESP;
          err_nxt   = ERR_BUS;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= OP_LW;
      addr_q  <= '0;
      sd_q    <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
      cnt_q   <= '0;
    end else begin
      err_q <= err_nxt;
      if (state == IDLE && req_valid) begin
        op_q    <= op;
        addr_q  <= addr;
        sd_q    <= store_data;
        rdata_q <= '0;
      end
      // Only an ack during ACCESS is honoured; stray acks elsewhere are dropped.
      if (state == ACCESS && mem_ack) begin
        rdata_q <= mem_rdata;
      end
      if (state == ACCESS && !mem_ack) begin
        cnt_q <= cnt_q + 8'd1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // Width decode from the latched op.
  always_comb begin
    is_store = (op_q == OP_SW) || (op_q == OP_SH) || (op_q == OP_SB);
    is_word  = (op_q == OP_LW) || (op_q == OP_SW);
    is_half  = (op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH);
    if (is_word) begin
      be_dec    = 4'b1111;
      wdata_dec = sd_q;
    end else if (is_half) begin
      be_dec    = 4'b0011 << addr_q[1:0];
      wdata_dec = {2{sd_q[15:0]}};
    end else begin
      be_dec    = 4'b0001 << addr_q[1:0];
      wdata_dec = {4{sd_q[7:0]}};
    end
  end

  // Lane select and extension of the captured read word.
  always_comb begin
    lane_h = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (addr_q[1:0])
      2'd0:    lane_b = rdata_q[7:0];
      2'd1:    lane_b = rdata_q[15:8];
      2'd2:    lane_b = rdata_q[23:16];
      default: lane_b = rdata_q[31:24];
    endcase
    case (op_q)
      OP_LW:   load_ext = rdata_q;
      OP_LH:   load_ext = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_ext = {16'h0000, lane_h};
      OP_LB:   load_ext = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_ext = {24'h000000, lane_b};
      default: load_ext = 32'h0000_0000;
    endcase
  end

  // Request outputs decode straight from state so a reset mid-access drops them at once.
  assign mem_req    = (state == ACCESS);
  assign mem_we     = (state == ACCESS) && is_store;
  assign mem_addr   = (state == ACCESS) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be     = (state == ACCESS) ? be_dec : 4'b0000;
  assign mem_wdata  = (state == ACCESS) ? wdata_dec : 32'h0000_0000;
  assign req_ready  = (state == IDLE);
  assign stall      = (state != IDLE);
  assign resp_valid = (state == RESP);
  assign err        = resp_valid ? err_q : ERR_OK;
  assign load_data  = (resp_valid && err_q == ERR_OK) ? load_ext : 32'h0000_0000;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store unit between the execute stage and the data memory (DM). It accepts one memory instruction at a time from EX and decodes byte/half/word width and sign. It drives a word-aligned request with byte enables into DM and holds it until DM acknowledges. It then returns an aligned, extended load result toward writeback. While an access is outstanding it signals a stall to the pipeline.

Parameters:
TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before a bus error is reported (legal range 2..255).
ADDR_W, 32, byte address width.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  1  EX presents a memory op.
req_ready  output  1  unit can accept an op this cycle.
op  input  3  0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB.
addr  input  ADDR_W  byte address from ALU.
store_data  input  32  rt value for stores.
mem_req  output  1  request to DM.
mem_we  output  1  DM write enable (MemWrite).
mem_addr  output  ADDR_W  word address to DM, low two bits always 0.
mem_be  output  4  byte enables.
mem_wdata  output  32  lane-shifted store data.
mem_ack  input  1  DM completes the access this cycle.
mem_rdata  input  32  DM read data, valid with mem_ack.
resp_valid  output  1  one-cycle pulse: op finished.
load_data  output  32  extended load result, valid with resp_valid; 0 for stores.
err  output  2  with resp_valid: 0=ok, 1=misaligned, 2=bus timeout.
stall  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous) forces the following; the unit is released on the first rising edge after reset=1.
  - state=IDLE, req_ready=1.
  - mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
  - resp_valid=0, load_data=0, err=0, stall=0, timeout counter=0.
- States are IDLE, ACCESS and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, the unit latches op, addr and store_data.
  - Alignment checks: LW/SW need addr[1:0]==0; LH/LHU/SH need addr[0]==0; byte ops are always aligned.
  - Misaligned: go to RESP with err=1. No memory request is issued and DM is never written.
  - Aligned: go to ACCESS. mem_req=1 from the next cycle.
- ACCESS:
  - req_ready=0.
  - mem_req, mem_we, mem_addr, mem_be and mem_wdata are held stable until mem_ack.
  - mem_addr = {addr[ADDR_W-1:2],2'b00}.
  - Byte enables: word=4'b1111; half=4'b0011<<addr[1:0]; byte=4'b0001<<addr[1:0].
  - Store data: mem_wdata = store_data replicated into the active lanes (half: {2{sd[15:0]}}; byte: {4{sd[7:0]}}).
  - mem_we=1 for ops 5..7.
  - On mem_ack:
    - Capture mem_rdata.
    - Drop mem_req and mem_we on the next edge.
    - Go to RESP with err=0.
  - Timeout counter:
    - Increments each ACCESS cycle without ack.
    - At TIMEOUT with no ack: drop mem_req, go to RESP with err=2, load_data=0.
    - An ack arriving in the same cycle the count reaches TIMEOUT wins and gives err=0.
- RESP:
  - resp_valid=1 for exactly one cycle, then return to IDLE.
  - Load extraction selects the byte or half lane by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - load_data returns to 0 when resp_valid is low.
- Throughput:
  - Minimum latency is req accept → resp_valid = 3 cycles when mem_ack arrives in the first ACCESS cycle.
  - Misaligned ops take 2 cycles.
  - There is no back-to-back accept. A new req is taken only in IDLE; req_valid seen outside IDLE is ignored, and EX must hold it while stall=1.
- stall = (state != IDLE).
- A spurious mem_ack outside ACCESS is ignored.
- Reset asserted mid-ACCESS aborts immediately: mem_req and mem_we fall asynchronously and no resp is generated.

Test Plan:
- LW addr=0x0000_0004, DM ack after 1 cycle with rdata=0x8765_4321 → mem_addr=0x4, mem_be=4'hF, mem_we=0; resp_valid 3 cycles after accept; load_data=0x8765_4321, err=0.
- SB addr=0x0000_0007 sd=0x0000_12AB → mem_addr=0x4, mem_be=4'b1000, mem_wdata=0xABABABAB, mem_we=1 held until ack; then resp with load_data=0. LB at the same address with rdata=0xAB00_0000 → 0xFFFF_FFAB; LBU → 0x0000_00AB.
- LH addr=0x0000_0002, rdata=0x8001_1234 → mem_be=4'b1100, load_data=0xFFFF_8001; LHU → 0x0000_8001.
- SW addr=0x0000_0006 → no mem_req ever asserted; resp_valid on the 2nd cycle with err=1. Same for LH addr=0x0000_0001.
- LW with mem_ack never asserted, TIMEOUT=16 → mem_req high for exactly 16 cycles, then resp err=2, load_data=0, back to IDLE with req_ready=1. Variant: ack in the 16th cycle → err=0.
- SW in ACCESS with reset pulled low mid-wait (not clock-aligned) → mem_req and mem_we drop in the same instant; after release, state=IDLE, resp_valid never pulsed, a subsequent LW completes normally.
